chacha_round_ctrl: RTL and testbench

// - Upstream sequencer for the four ChaCha column-slice quarter-round units (one per column, addr_hi 0..3).
// - Gates host byte writes into the state and drives write/calc/shift/add_back/step/addr/data to all four slices.
// - On start: runs ROUNDS/2 double-rounds (column, diagonalise, diagonal, undiagonalise), then one add-back.
// - Registers the host read-back byte from the OR of the four slice data_out lanes.

---
 rtl/chacha_round_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_chacha_round_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/chacha_round_ctrl.sv
// chacha_round_ctrl
//   Sequencer for the four ChaCha column-slice quarter-round units. It gates
//   host byte writes into the state, runs ROUNDS/2 double-rounds (column,
//   diagonalise, diagonal, undiagonalise) followed by one add-back, and
//   registers the host read-back byte from the four slice output lanes.
//
// Parameters
//   ROUNDS      total ChaCha rounds, even, 2..62
//
// Ports
//   clk, rst    clock (posedge) and synchronous active-high reset
//   start       begin a block computation (honoured in IDLE/DONE only)
//   host_we     host byte write strobe (dropped while busy)
//   host_addr   host byte address {row, col, byte}
//   host_wdata  host write byte
//   host_rdata  registered OR of the four slice lanes, 1-cycle latency
//   busy        high while sequencing
//   done        sticky result-valid flag
//   q_write / q_calc / q_shift / q_add_back / q_step
//               strobes broadcast to all four slices
//   q_addr, q_data  host address/data forwarded combinationally
//   q_rdata     {slice3, slice2, slice1, slice0} data_out lanes
//
// Configuration
//   CHACHA_CTRL_SINGLE_STEP_EN  adds input `advance`; sequencing states only
//                               strobe and progress in cycles with advance=1.

module chacha_round_ctrl #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        host_we,
    input  logic [5:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        busy,
    output logic        done,
    output logic        q_write,
    output logic        q_calc,
    output logic        q_shift,
    output logic        q_add_back,
    output logic [1:0]  q_step,
    output logic [5:0]  q_addr,
    output logic [7:0]  q_data,
`ifdef CHACHA_CTRL_SINGLE_STEP_EN
    input  logic        advance,
`endif
    input  logic [31:0] q_rdata
);

    localparam logic [5:0] DOUBLES = 6'(ROUNDS / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COL,
        S_DIAG,
        S_DGCALC,
        S_UNDIAG,
        S_ADD,
        S_DONE
    } state_t;

    state_t     state;
    logic [5:0] round_cnt;
    logic [2:0] sub_cnt;
    logic       adv;

`ifdef CHACHA_CTRL_SINGLE_STEP_EN
    assign adv = advance;
`else
    assign adv = 1'b1;
`endif

    assign q_addr = host_addr;
    assign q_data = host_wdata;

    // Per-cycle column-rotation step while diagonalising: rows b, c, d move
    // by 1, 2, 3 columns as 1,2,2,3,3,3 single-column shifts.
    function automatic logic [1:0] diag_step(input logic [2:0] s);
        case (s)
            3'd0:      return 2'd1;
            3'd1, 3'd2: return 2'd2;
            default:   return 2'd3;
        endcase
    endfunction

    // Undiagonalise completes each row rotation to a full 4 columns.
    function automatic logic [1:0] undiag_step(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2: return 2'd1;
            3'd3, 3'd4:       return 2'd2;
            default:          return 2'd3;
        endcase
    endfunction

    // Moore decode of the sequencing state; only q_write looks at host_we.
    always_comb begin
        q_write    = 1'b0;
        q_calc     = 1'b0;
        q_shift    = 1'b0;
        q_add_back = 1'b0;
        q_step     = 2'd0;
        case (state)
            S_IDLE, S_DONE: q_write = host_we;
            S_COL, S_DGCALC: begin
                q_calc = adv;
                q_step = adv ? sub_cnt[1:0] : 2'd0;
            end
            S_DIAG: begin
                q_shift = adv;
                q_step  = adv ? diag_step(sub_cnt) : 2'd0;
            end
            S_UNDIAG: begin
                q_shift = adv;
                q_step  = adv ? undiag_step(sub_cnt) : 2'd0;
            end
            S_ADD: q_add_back = adv;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            round_cnt  <= '0;
            sub_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_rdata <= q_rdata[7:0] | q_rdata[15:8] | q_rdata[23:16] | q_rdata[31:24];
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_COL;
                        round_cnt <= '0;
                        sub_cnt   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end else if (host_we) begin
                        done <= 1'b0;
                    end
                end
                S_COL: if (adv) begin
                    if (sub_cnt == 3'd3) begin
                        sub_cnt <= '0;
                        state   <= S_DIAG;
                    end else begin
                        sub_cnt <= sub_cnt + 3'd1;
                    end
                end
                S_DIAG: if (adv) begin
                    if (sub_cnt == 3'd5) begin
                        sub_cnt <= '0;
                        state   <= S_DGCALC;
                    end else begin
                        sub_cnt <= sub_cnt + 3'd1;
                    end
                end
                S_DGCALC: if (adv) begin
                    if (sub_cnt == 3'd3) begin
                        sub_cnt <= '0;
                        state   <= S_UNDIAG;
                    end else begin
                        sub_cnt <= sub_cnt + 3'd1;
                    end
                end
                S_UNDIAG: if (adv) begin
                    if (sub_cnt == 3'd5) begin
                        sub_cnt   <= '0;
                        round_cnt <= round_cnt + 6'd1;
                        state     <= (round_cnt + 6'd1 == DOUBLES) ? S_ADD : S_COL;
                    end else begin
                        sub_cnt <= sub_cnt + 3'd1;
                    end
                end
                S_ADD: if (adv) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// tb_chacha_round_ctrl
//   Self-checking bench for chacha_round_ctrl (ROUNDS=2). A byte array stands
//   in for the slice state so writes and read-back can be observed; expected
//   strobe traces are built from the round schedule as a list of steps.

module tb_chacha_round_ctrl;

    localparam int unsigned R   = 2;
    localparam int unsigned RUN = 10 * R + 1;

    logic        clk = 1'b0;
    logic        rst, start, host_we;
    logic [5:0]  host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        busy, done;
    logic        q_write, q_calc, q_shift, q_add_back;
    logic [1:0]  q_step;
    logic [5:0]  q_addr;
    logic [7:0]  q_data;
    logic [31:0] q_rdata;

    logic [7:0]  mem [64];
    logic [7:0]  exp_mem [64];
    logic        use_rnd;
    logic [31:0] rnd_word;
    logic [7:0]  exp_rd;
    logic [5:0]  trace [$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    chacha_round_ctrl #(.ROUNDS(R)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .busy       (busy),
        .done       (done),
        .q_write    (q_write),
        .q_calc     (q_calc),
        .q_shift    (q_shift),
        .q_add_back (q_add_back),
        .q_step     (q_step),
        .q_addr     (q_addr),
        .q_data     (q_data),
`ifdef CHACHA_CTRL_SINGLE_STEP_EN
        .advance    (1'b1),
`endif
        .q_rdata    (q_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return (i == 0) ? 8'h61 : 8'(i * 37 + 5);
    endfunction

    function automatic logic [7:0] or_lanes(input logic [31:0] w);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r = r | w[8*b +: 8];
        return r;
    endfunction

    // Slice stand-in: column addr[3:2] owns the byte and drives only its lane.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_byte(i);
        end else if (q_write) begin
            mem[q_addr] <= q_data;
        end
    end

    assign q_rdata = use_rnd ? rnd_word
                             : ({24'd0, mem[host_addr]} << {host_addr[3:2], 3'b000});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Vector layout: {write, calc, shift, add_back, step[1:0]}.
    function automatic void build_trace();
        int dsteps [6];
        int usteps [6];
        dsteps = '{1, 2, 2, 3, 3, 3};
        usteps = '{1, 1, 1, 2, 2, 3};
        trace.delete();
        for (int d = 0; d < int'(R / 2); d++) begin
            for (int s = 0; s < 4; s++) trace.push_back(6'b010000 | 6'(s));
            for (int s = 0; s < 6; s++) trace.push_back(6'b001000 | 6'(dsteps[s]));
            for (int s = 0; s < 4; s++) trace.push_back(6'b010000 | 6'(s));
            for (int s = 0; s < 6; s++) trace.push_back(6'b001000 | 6'(usteps[s]));
        end
        trace.push_back(6'b000100);
    endfunction

    function automatic logic [5:0] strobes();
        return {q_write, q_calc, q_shift, q_add_back, q_step};
    endfunction

    task automatic check_mem(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) errs++;
        check(tag, 32'(errs), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; host_we = 1'b0; use_rnd = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        @(negedge clk);
        check("rst_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_byte(i);
    endtask

    // Entered just after a negedge in IDLE/DONE; start is asserted this cycle.
    task automatic run_block(input logic we0, input logic [5:0] a0, input logic [7:0] d0);
        start = 1'b1; host_we = we0; host_addr = a0; host_wdata = d0; use_rnd = 1'b0;
        #1;
        check("start_write", 32'(q_write), 32'(we0));
        if (we0) exp_mem[a0] = d0;
        exp_rd = or_lanes(q_rdata);
        for (int c = 1; c <= int'(RUN) + 1; c++) begin
            @(negedge clk);
            check("rdata_run", 32'(host_rdata), 32'(exp_rd));
            start      = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 6'($urandom);
            host_wdata = 8'($urandom);
            use_rnd    = 1'($urandom_range(0, 1));
            rnd_word   = $urandom;
            if (c == 10) begin
                host_we = 1'b1; host_addr = 6'h10; host_wdata = 8'hAA;
            end
            if (c == int'(RUN) + 1) begin
                start = 1'b0; host_we = 1'b0;
            end
            #1;
            check("strobes", 32'(strobes()), (c <= int'(RUN)) ? 32'(trace[c-1]) : 32'd0);
            check("busy", 32'(busy), (c <= int'(RUN)) ? 32'd1 : 32'd0);
            check("done", 32'(done), (c <= int'(RUN)) ? 32'd0 : 32'd1);
            exp_rd = or_lanes(q_rdata);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        use_rnd = 1'b0; rnd_word = '0;
        build_trace();
        do_reset();
        host_addr = 6'h00;
        @(negedge clk);
        check("rd_latency", 32'(host_rdata), 32'h61);
        check("idle_busy", 32'(busy), 32'd0);

        // Random host writes and reads while idle.
        for (int k = 0; k < 12; k++) begin
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 6'($urandom);
            host_wdata = 8'($urandom);
            #1;
            check("idle_write", 32'(q_write), 32'(host_we));
            exp_rd = or_lanes(q_rdata);
            if (host_we) exp_mem[host_addr] = host_wdata;
            @(negedge clk);
            check("idle_rdata", 32'(host_rdata), 32'(exp_rd));
        end
        host_we = 1'b0;
        @(negedge clk);
        check_mem("mem_idle");

        run_block(1'b0, 6'h00, 8'h00);
        @(negedge clk);
        check_mem("mem_busy_drop");

        run_block(1'b1, 6'h30, 8'h5C);
        @(negedge clk);
        check_mem("mem_start_we");
        check("mem30", 32'(mem[6'h30]), 32'h5C);

        // Host write alone in DONE clears done.
        host_we = 1'b1; host_addr = 6'h21; host_wdata = 8'h3C; start = 1'b0;
        #1;
        check("done_write", 32'(q_write), 32'd1);
        check("done_before", 32'(done), 32'd1);
        exp_mem[6'h21] = 8'h3C;
        @(negedge clk);
        host_we = 1'b0;
        check("done_cleared", 32'(done), 32'd0);
        check("busy_after_we", 32'(busy), 32'd0);
        check_mem("mem_done_we");

        // Reset in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
